// File: rtl/m_vector_streamer.sv
// Burst streamer: issues BURST_LEN strided reads per start, captures the returning words into a
// credit-limited FIFO and walks layer/minor/major positions across bursts.
module m_vector_streamer #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ROW_W       = 6,
   parameter int unsigned Q_BITS      = 2,
   parameter int unsigned LAYERS      = 4,
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned ROW_OFFSET  = 4,
   parameter int unsigned ROW_STRIDE  = 4,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   localparam int unsigned ADDR_W     = ROW_W + 2 * Q_BITS
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              en,
   input  logic              start,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              sweep_done
);

   localparam int unsigned KW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned NW = $clog2(FIFO_DEPTH + MEM_LATENCY + 2);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                 state_q;
   logic [KW-1:0]          k_q;
   logic [ROW_W-1:0]       row_q;
   logic [LW-1:0]          layer_q;
   logic [Q_BITS-1:0]      minor_q;
   logic [Q_BITS-1:0]      major_q;
   logic                   mem_last_q;
   logic [MEM_LATENCY-1:0] vld_q;
   logic [MEM_LATENCY-1:0] lst_q;
   logic [DATA_W-1:0]      fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]  fifo_last;
   logic [PW-1:0]          wr_ptr_q;
   logic [PW-1:0]          rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic [2*Q_BITS-1:0]    col;
   logic [NW-1:0]          credit;
   logic                   push;
   logic                   pop;
   logic                   fire;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      col = '0;
      for (int i = 0; i < Q_BITS; i++) begin
         col[2*i+1] = major_q[i];
         col[2*i]   = minor_q[i];
      end
   end

   // Every word already issued but not yet in the FIFO holds a slot; the same-cycle pop frees one.
   always_comb begin
      credit = NW'(count_q) + NW'(mem_en) - NW'(pop);
      for (int i = 0; i < MEM_LATENCY; i++) begin
         credit = credit + NW'(vld_q[i]);
      end
   end

   assign out_valid = (count_q != '0);
   assign pop       = out_valid & out_ready;
   assign push      = vld_q[MEM_LATENCY-1];
   assign fire      = (state_q == StIssue) && en && (credit < NW'(FIFO_DEPTH));
   assign out_data  = fifo_data[rd_ptr_q];
   assign out_last  = out_valid & fifo_last[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= StIdle;
         busy       <= 1'b0;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         mem_last_q <= 1'b0;
         k_q        <= '0;
         row_q      <= '0;
         layer_q    <= '0;
         minor_q    <= '0;
         major_q    <= '0;
         sweep_done <= 1'b0;
      end else begin
         mem_en     <= 1'b0;
         mem_last_q <= 1'b0;
         sweep_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StIssue;
                  busy    <= 1'b1;
                  k_q     <= '0;
                  row_q   <= ROW_W'(ROW_OFFSET) + ROW_W'(layer_q);
               end
            end
            StIssue: begin
               if (fire) begin
                  mem_en     <= 1'b1;
                  mem_addr   <= {row_q, col};
                  mem_last_q <= (k_q == KW'(BURST_LEN - 1));
                  row_q      <= row_q + ROW_W'(ROW_STRIDE);
                  k_q        <= k_q + KW'(1);
                  if (k_q == KW'(BURST_LEN - 1)) state_q <= StDrain;
               end
            end
            StDrain: begin
               if (pop && out_last) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  if (layer_q == LW'(LAYERS - 1)) begin
                     layer_q <= '0;
                     if (minor_q == '1) begin
                        minor_q <= '0;
                        if (major_q == '1) begin
                           major_q    <= '0;
                           sweep_done <= 1'b1;
                        end else begin
                           major_q <= major_q + Q_BITS'(1);
                        end
                     end else begin
                        minor_q <= minor_q + Q_BITS'(1);
                     end
                  end else begin
                     layer_q <= layer_q + LW'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         vld_q    <= '0;
         lst_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         vld_q[0] <= mem_en;
         lst_q[0] <= mem_last_q;
         for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr_q] <= mem_rdata;
         fifo_last[wr_ptr_q] <= lst_q[MEM_LATENCY-1];
      end
   end

endmodule

// File: tb/tb_m_vector_streamer.sv
// Bench for m_vector_streamer: default instance plus a BURST_LEN=1 / latency-1 / depth-2 instance,
// both served by address-echo memories and checked against a closed-form address model.
module tb_m_vector_streamer;

   localparam int ROW_OFF = 4;
   localparam int ROW_STR = 4;
   localparam int NPOS    = 64;

   logic        clock = 1'b0;
   logic        clear      [2];
   logic        en         [2];
   logic        start      [2];
   logic        out_ready  [2];
   logic        busy       [2];
   logic        mem_en     [2];
   logic        out_valid  [2];
   logic        out_last   [2];
   logic        sweep_done [2];
   logic [9:0]  mem_addr   [2];
   logic [15:0] mem_rdata  [2];
   logic [15:0] out_data   [2];
   logic [9:0]  h0         [2];
   logic [9:0]  h1;

   int n_cmp  = 0;
   int n_fail = 0;
   int bcnt [2];

   always #5 clock = ~clock;

   m_vector_streamer u_dut0 (
      .clock(clock), .clear(clear[0]), .en(en[0]), .start(start[0]), .busy(busy[0]),
      .mem_addr(mem_addr[0]), .mem_en(mem_en[0]), .mem_rdata(mem_rdata[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_last(out_last[0]), .sweep_done(sweep_done[0])
   );

   m_vector_streamer #(.BURST_LEN(1), .MEM_LATENCY(1), .FIFO_DEPTH(2)) u_dut1 (
      .clock(clock), .clear(clear[1]), .en(en[1]), .start(start[1]), .busy(busy[1]),
      .mem_addr(mem_addr[1]), .mem_en(mem_en[1]), .mem_rdata(mem_rdata[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_last(out_last[1]), .sweep_done(sweep_done[1])
   );

   // Memories return the read address as data, 2 and 1 cycles after the strobe respectively.
   always @(posedge clock) begin
      h0[1] <= h0[0];
      h0[0] <= mem_addr[0];
      h1    <= mem_addr[1];
   end
   assign mem_rdata[0] = 16'(h0[1]);
   assign mem_rdata[1] = 16'(h1);

   function automatic logic [9:0] exp_addr(input int b, input int k);
      int pos, layer, minor, major;
      logic [5:0] row;
      logic [3:0] col;
      pos   = b % NPOS;
      layer = pos % 4;
      minor = (pos / 4) % 4;
      major = pos / 16;
      row   = 6'((ROW_OFF + layer + ROW_STR * k) % 64);
      for (int i = 0; i < 2; i++) begin
         col[2*i]   = minor[i];
         col[2*i+1] = major[i];
      end
      return {row, col};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: en/ready high; 1: random en/ready; 2: ready low for 12 cycles then high.
   task automatic run_burst(input int d, input int mode);
      int bl, fd, issued, popped, cyc;
      logic prev_en;
      bl = (d == 0) ? 8 : 1;
      fd = (d == 0) ? 4 : 2;
      issued = 0;
      popped = 0;
      cyc = 0;
      start[d] = 1'b1;
      @(negedge clock);
      start[d] = 1'b0;
      chk("busy_rise", 32'(busy[d]), 1);
      prev_en = en[d];
      while (popped < bl && cyc < 400) begin
         if (!prev_en) chk("stall_no_issue", 32'(mem_en[d]), 0);
         if (mem_en[d]) begin
            chk("issue_addr", 32'(mem_addr[d]), 32'(exp_addr(bcnt[d], issued)));
            issued++;
            chk("issue_count_le_burst", 32'(issued <= bl), 1);
         end
         chk("credit_bound", 32'((issued - popped) <= fd), 1);
         chk("sweep_quiet", 32'(sweep_done[d]), 0);
         if (mode == 2 && cyc == 11) begin
            chk("held_issue_count", 32'(issued), 32'(fd));
            chk("held_valid", 32'(out_valid[d]), 1);
            chk("held_head", 32'(out_data[d]), 32'(exp_addr(bcnt[d], 0)));
         end
         case (mode)
            1: begin
               en[d]        = ($urandom_range(3) != 0);
               out_ready[d] = 1'($urandom_range(1));
            end
            2: begin
               en[d]        = 1'b1;
               out_ready[d] = (cyc >= 12);
            end
            default: begin
               en[d]        = 1'b1;
               out_ready[d] = 1'b1;
            end
         endcase
         if (out_valid[d] && out_ready[d]) begin
            chk("out_data", 32'(out_data[d]), 32'(exp_addr(bcnt[d], popped)));
            chk("out_last", 32'(out_last[d]), 32'(popped == bl - 1));
            popped++;
         end
         prev_en = en[d];
         cyc++;
         @(negedge clock);
      end
      chk("burst_complete", 32'(popped), 32'(bl));
      chk("burst_issues", 32'(issued), 32'(bl));
      bcnt[d]++;
      chk("busy_fall", 32'(busy[d]), 0);
      chk("sweep_done", 32'(sweep_done[d]), 32'((bcnt[d] % NPOS) == 0));
      en[d]        = 1'b1;
      out_ready[d] = 1'b1;
   endtask

   task automatic pulse_clear(input int d);
      clear[d] = 1'b1;
      @(negedge clock);
      clear[d] = 1'b0;
      bcnt[d] = 0;
   endtask

   initial begin
      int issued;
      for (int d = 0; d < 2; d++) begin
         clear[d] = 1'b1;
         en[d] = 1'b1;
         start[d] = 1'b0;
         out_ready[d] = 1'b1;
         bcnt[d] = 0;
      end
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         clear[d] = 1'b0;
         chk("rst_busy", 32'(busy[d]), 0);
         chk("rst_mem_en", 32'(mem_en[d]), 0);
         chk("rst_mem_addr", 32'(mem_addr[d]), 0);
         chk("rst_out_valid", 32'(out_valid[d]), 0);
         chk("rst_out_last", 32'(out_last[d]), 0);
         chk("rst_sweep", 32'(sweep_done[d]), 0);
      end

      // Plain burst, then bursts walking layer and minor (fifth starts at 0x041, ninth at 0x044).
      run_burst(0, 0);
      for (int i = 0; i < 8; i++) run_burst(0, 1);
      run_burst(0, 2);

      // Clear after three issues with data parked in the FIFO and still in flight.
      pulse_clear(0);
      out_ready[0] = 1'b0;
      start[0] = 1'b1;
      @(negedge clock);
      start[0] = 1'b0;
      issued = 0;
      for (int c = 0; c < 50 && issued < 3; c++) begin
         @(negedge clock);
         if (mem_en[0]) issued++;
      end
      chk("clear_wait", 32'(issued), 3);
      out_ready[0] = 1'b1;
      pulse_clear(0);
      chk("clr_busy", 32'(busy[0]), 0);
      chk("clr_mem_en", 32'(mem_en[0]), 0);
      chk("clr_mem_addr", 32'(mem_addr[0]), 0);
      chk("clr_out_valid", 32'(out_valid[0]), 0);
      chk("clr_out_last", 32'(out_last[0]), 0);
      chk("clr_sweep", 32'(sweep_done[0]), 0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         chk("clr_no_stale", 32'(out_valid[0]), 0);
      end
      run_burst(0, 0);

      // Full sweep and wrap on both configurations.
      pulse_clear(0);
      for (int i = 0; i < NPOS + 1; i++) run_burst(0, (i % 3 == 0) ? 0 : 1);
      for (int i = 0; i < NPOS + 1; i++) run_burst(1, (i % 2 == 0) ? 0 : 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
